// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: stimulus/result bundle between a gate-experiment top and the checker
interface truth_table_checker_if #(parameter int N_INPUTS = 3);
    localparam int ERR_W = N_INPUTS + 1;
    logic                start;
    logic [2:0]          mode;
    logic                dut_y;
    logic [N_INPUTS-1:0] stim;
    logic                busy;
    logic                done;
    logic                pass;
    logic                bad_mode;
    logic [ERR_W-1:0]    err_count;
    logic [N_INPUTS-1:0] first_fail_vec;
    logic                first_fail_vld;
    modport master (
        output start, mode, dut_y,
        input  stim, busy, done, pass, bad_mode, err_count, first_fail_vec, first_fail_vld
    );
    modport slave (
        input  start, mode, dut_y,
        output stim, busy, done, pass, bad_mode, err_count, first_fail_vec, first_fail_vld
    );
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustive vector sweep of an N-input gate DUT against a selectable reference
module truth_table_checker #(
    parameter int N_INPUTS    = 3,
    parameter int HOLD_CYCLES = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    truth_table_checker_if.slave bus
);
    localparam int ERR_W = N_INPUTS + 1;
    localparam int HW    = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [2:0]       mode_q;
    logic [HW-1:0]    hold_cnt;
    logic             ref_y;
    logic             mism;
    logic [ERR_W-1:0] err_next;
    always_comb begin
        ref_y = mode_q == 3'd0 ? &bus.stim :
                mode_q == 3'd1 ? |bus.stim :
                mode_q == 3'd2 ? ~&bus.stim :
                mode_q == 3'd3 ? ~|bus.stim :
                mode_q == 3'd4 ? ^bus.stim :
                mode_q == 3'd5 ? ~^bus.stim : 1'b0;
        mism     = bus.dut_y !== ref_y;
        err_next = bus.err_count + ERR_W'(mism);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            mode_q             <= '0;
            hold_cnt           <= '0;
            bus.stim           <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.pass           <= 1'b0;
            bus.bad_mode       <= 1'b0;
            bus.err_count      <= '0;
            bus.first_fail_vec <= '0;
            bus.first_fail_vld <= 1'b0;
        end else if (state != RUN) begin
            if (bus.start) begin
                mode_q             <= bus.mode;
                hold_cnt           <= '0;
                bus.stim           <= '0;
                bus.pass           <= 1'b0;
                bus.err_count      <= '0;
                bus.first_fail_vec <= '0;
                bus.first_fail_vld <= 1'b0;
                bus.bad_mode       <= bus.mode[2] & bus.mode[1];
                bus.done           <= bus.mode[2] & bus.mode[1];
                bus.busy           <= ~(bus.mode[2] & bus.mode[1]);
                state              <= (bus.mode[2] & bus.mode[1]) ? DONE : RUN;
            end
        end else if (hold_cnt != HW'(HOLD_CYCLES - 1)) begin
            hold_cnt <= hold_cnt + HW'(1);
        end else begin
            bus.err_count <= err_next;
            if (mism && !bus.first_fail_vld) begin
                bus.first_fail_vec <= bus.stim;
                bus.first_fail_vld <= 1'b1;
            end
            if (&bus.stim) begin
                state    <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.pass <= err_next == '0;
            end else begin
                bus.stim <= bus.stim + N_INPUTS'(1);
                hold_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed checks of the truth-table sweep engine against a 3-input NAND DUT
module tb_truth_table_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stuck = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    truth_table_checker_if #(.N_INPUTS(3)) ifc ();
    truth_table_checker #(.N_INPUTS(3), .HOLD_CYCLES(10)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
    always #5 clk = ~clk;
    assign ifc.dut_y = stuck | ~&ifc.stim;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input logic [2:0] m, input bit disturb, output int cycles);
        @(posedge clk); #1;
        ifc.mode  = m;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        check("accept_busy", 32'(ifc.busy), 32'd1);
        check("accept_stim", 32'(ifc.stim), 32'd0);
        cycles = 0;
        while (!ifc.done && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
            if (disturb && cycles == 20) begin
                ifc.start = 1'b1;
                ifc.mode  = 3'd4;
            end
            if (disturb && cycles == 21) ifc.start = 1'b0;
            if (cycles % 20 == 5 && cycles < 80) check("stim_walk", 32'(ifc.stim), 32'(cycles / 10));
        end
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.mode  = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_done", 32'(ifc.done), 32'd0);
        check("rst_pass", 32'(ifc.pass), 32'd0);
        check("rst_stim", 32'(ifc.stim), 32'd0);
        check("rst_err", 32'(ifc.err_count), 32'd0);
        check("rst_vld", 32'(ifc.first_fail_vld), 32'd0);
        check("rst_bad", 32'(ifc.bad_mode), 32'd0);
        rst_n = 1'b1;

        run_sweep(3'd2, 1'b0, lat);
        check("t1_latency", 32'(lat), 32'd80);
        check("t1_pass", 32'(ifc.pass), 32'd1);
        check("t1_err", 32'(ifc.err_count), 32'd0);
        check("t1_vld", 32'(ifc.first_fail_vld), 32'd0);
        check("t1_busy", 32'(ifc.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_done_held", 32'(ifc.done), 32'd1);

        stuck = 1'b1;
        run_sweep(3'd2, 1'b0, lat);
        check("t2_latency", 32'(lat), 32'd80);
        check("t2_err", 32'(ifc.err_count), 32'd1);
        check("t2_ffv", 32'(ifc.first_fail_vec), 32'd7);
        check("t2_vld", 32'(ifc.first_fail_vld), 32'd1);
        check("t2_pass", 32'(ifc.pass), 32'd0);
        stuck = 1'b0;

        run_sweep(3'd4, 1'b0, lat);
        check("t3_err", 32'(ifc.err_count), 32'd5);
        check("t3_ffv", 32'(ifc.first_fail_vec), 32'd0);
        check("t3_vld", 32'(ifc.first_fail_vld), 32'd1);
        check("t3_pass", 32'(ifc.pass), 32'd0);

        @(posedge clk); #1;
        ifc.mode  = 3'd2;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        check("t4_restart_clears_done", 32'(ifc.done), 32'd0);
        lat = 0;
        while (ifc.stim !== 3'd4 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t4_reach_stim4", 32'(ifc.stim), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_busy", 32'(ifc.busy), 32'd0);
        check("t4_async_stim", 32'(ifc.stim), 32'd0);
        check("t4_async_err", 32'(ifc.err_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_sweep(3'd2, 1'b0, lat);
        check("t4_latency", 32'(lat), 32'd80);
        check("t4_pass", 32'(ifc.pass), 32'd1);

        run_sweep(3'd2, 1'b1, lat);
        check("t5_latency", 32'(lat), 32'd80);
        check("t5_pass", 32'(ifc.pass), 32'd1);
        check("t5_err", 32'(ifc.err_count), 32'd0);
        check("t5_vld", 32'(ifc.first_fail_vld), 32'd0);

        @(posedge clk); #1;
        ifc.mode  = 3'd6;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        check("t6_done", 32'(ifc.done), 32'd1);
        check("t6_pass", 32'(ifc.pass), 32'd0);
        check("t6_bad", 32'(ifc.bad_mode), 32'd1);
        check("t6_busy", 32'(ifc.busy), 32'd0);
        check("t6_stim", 32'(ifc.stim), 32'd0);
        check("t6_err", 32'(ifc.err_count), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t6_busy_later", 32'(ifc.busy), 32'd0);
        check("t6_done_later", 32'(ifc.done), 32'd1);

        run_sweep(3'd2, 1'b0, lat);
        check("t7_bad_cleared", 32'(ifc.bad_mode), 32'd0);
        check("t7_pass", 32'(ifc.pass), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
